// File: rtl/count_global_multi_if.sv
// Channel-side signal bundle for count_global_multi: per-channel start/stop requests in,
// per-channel count and status out.
interface count_global_multi_if #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned NCH   = 4
);
  logic [NCH-1:0]       srdyi_counter;
  logic [NCH-1:0]       clk_stop;
  logic [NCH*WIDTH-1:0] count_global;
  logic [NCH-1:0]       running;
  logic [NCH-1:0]       done;
  logic [NCH-1:0]       overflow;

  modport master (
    output srdyi_counter,
    output clk_stop,
    input  count_global,
    input  running,
    input  done,
    input  overflow
  );

  modport slave (
    input  srdyi_counter,
    input  clk_stop,
    output count_global,
    output running,
    output done,
    output overflow
  );
endinterface

// File: rtl/count_global_multi.sv
// Multi-channel start/stop cycle counter: each channel counts cycles from a start edge to a
// stop request, with done pulse, sticky overflow and wrap-or-saturate behaviour.
module count_global_multi #(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned NCH      = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                   clk,
  input  logic                   GlobalReset,
  count_global_multi_if.slave    bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                        state_q [NCH];
  state_e                        state_d [NCH];
  logic [NCH-1:0][WIDTH-1:0]     cnt_q, cnt_d;
  logic [NCH-1:0]                ovf_q, ovf_d;
  logic [NCH-1:0]                done_q, done_d;
  logic [NCH-1:0]                hist_q;
  logic [NCH-1:0]                start_ev;
  logic [NCH-1:0]                running;

  assign start_ev = bus.srdyi_counter & ~hist_q;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      ovf_d[i]   = ovf_q[i];
      done_d[i]  = 1'b0;
      unique case (state_q[i])
        StIdle: begin
          if (start_ev[i]) begin
            state_d[i] = StRun;
            cnt_d[i]   = '0;
            ovf_d[i]   = 1'b0;
          end
        end
        StRun: begin
          // A start edge restarts the channel and beats a simultaneous stop.
          if (start_ev[i]) begin
            cnt_d[i] = '0;
            ovf_d[i] = 1'b0;
          end else begin
            if (cnt_q[i] == {WIDTH{1'b1}}) begin
              ovf_d[i] = 1'b1;
              cnt_d[i] = SATURATE ? {WIDTH{1'b1}} : '0;
            end else begin
              cnt_d[i] = cnt_q[i] + WIDTH'(1);
            end
            if (bus.clk_stop[i]) begin
              state_d[i] = StIdle;
              done_d[i]  = 1'b1;
            end
          end
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      hist_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= '0;
      done_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= StIdle;
      end
    end else begin
      hist_q <= bus.srdyi_counter;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  always_comb begin
    running = '0;
    for (int i = 0; i < NCH; i++) begin
      running[i] = (state_q[i] == StRun);
    end
  end

  assign bus.count_global = cnt_q;
  assign bus.running      = running;
  assign bus.done         = done_q;
  assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_count_global_multi.sv
// Bench for count_global_multi: a wrapping and a saturating instance share one directed
// stimulus stream; per-cycle expected snapshots go through queues to independent monitors.
module tb_count_global_multi;
  localparam int unsigned W = 5;
  localparam int unsigned N = 4;

  typedef struct packed {
    logic [N-1:0][W-1:0] cnt;
    logic [N-1:0]        run;
    logic [N-1:0]        done;
    logic [N-1:0]        ovf;
    logic [N-1:0]        hist;
  } mstate_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mstate_t m0 = '0;
  mstate_t m1 = '0;
  mstate_t q0[$];
  mstate_t q1[$];

  count_global_multi_if #(.WIDTH(W), .NCH(N)) bus0 ();
  count_global_multi_if #(.WIDTH(W), .NCH(N)) bus1 ();

  count_global_multi #(.WIDTH(W), .NCH(N), .SATURATE(1'b0)) u_wrap (
    .clk         (clk),
    .GlobalReset (rst),
    .bus         (bus0.slave)
  );

  count_global_multi #(.WIDTH(W), .NCH(N), .SATURATE(1'b1)) u_sat (
    .clk         (clk),
    .GlobalReset (rst),
    .bus         (bus1.slave)
  );

  always #5 clk = ~clk;

  // Reference behaviour of one clock edge for all channels.
  function automatic mstate_t model_next(mstate_t s, logic [N-1:0] srdy, logic [N-1:0] stop,
                                         bit r, bit sat);
    mstate_t n;
    int      v;
    int      maxv;
    maxv = (1 << W) - 1;
    n = s;
    if (r) return '0;
    n.hist = srdy;
    for (int c = 0; c < N; c++) begin
      n.done[c] = 1'b0;
      if (srdy[c] && !s.hist[c]) begin
        n.run[c] = 1'b1;
        n.cnt[c] = '0;
        n.ovf[c] = 1'b0;
      end else if (s.run[c]) begin
        v = int'(s.cnt[c]) + 1;
        if (v > maxv) begin
          n.ovf[c] = 1'b1;
          v = sat ? maxv : 0;
        end
        n.cnt[c] = 5'(v);
        if (stop[c]) begin
          n.run[c]  = 1'b0;
          n.done[c] = 1'b1;
        end
      end
    end
    return n;
  endfunction

  task automatic step(input logic [N-1:0] srdy, input logic [N-1:0] stop, input bit r);
    @(negedge clk);
    bus0.srdyi_counter = srdy;
    bus0.clk_stop      = stop;
    bus1.srdyi_counter = srdy;
    bus1.clk_stop      = stop;
    rst                = r;
    m0 = model_next(m0, srdy, stop, r, 1'b0);
    m1 = model_next(m1, srdy, stop, r, 1'b1);
    q0.push_back(m0);
    q1.push_back(m1);
    @(posedge clk);
    #2;
  endtask

  task automatic hcheck(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    mstate_t e;
    #2;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      checks++;
      if ({bus0.count_global, bus0.running, bus0.done, bus0.overflow} !==
          {e.cnt, e.run, e.done, e.ovf}) begin
        errors++;
        $display("FAIL wrap_snapshot t=%0t: cnt=%h run=%b done=%b ovf=%b expected cnt=%h run=%b done=%b ovf=%b",
                 $time, bus0.count_global, bus0.running, bus0.done, bus0.overflow,
                 e.cnt, e.run, e.done, e.ovf);
      end
    end
  end

  always @(posedge clk) begin
    mstate_t e;
    #2;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      checks++;
      if ({bus1.count_global, bus1.running, bus1.done, bus1.overflow} !==
          {e.cnt, e.run, e.done, e.ovf}) begin
        errors++;
        $display("FAIL sat_snapshot t=%0t: cnt=%h run=%b done=%b ovf=%b expected cnt=%h run=%b done=%b ovf=%b",
                 $time, bus1.count_global, bus1.running, bus1.done, bus1.overflow,
                 e.cnt, e.run, e.done, e.ovf);
      end
    end
  end

  function automatic int ch0(input int c);
    return int'(bus0.count_global[c*W +: W]);
  endfunction

  function automatic int ch1(input int c);
    return int'(bus1.count_global[c*W +: W]);
  endfunction

  initial begin
    bus0.srdyi_counter = '0;
    bus0.clk_stop      = '0;
    bus1.srdyi_counter = '0;
    bus1.clk_stop      = '0;

    // Reset
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);
    hcheck("reset_count", int'(bus0.count_global), 0);
    hcheck("reset_flags", int'({bus0.running, bus0.done, bus0.overflow}), 0);

    // Basic count on ch0: start cycle 0, stop cycle 3
    step(4'b0001, 4'b0000, 1'b0);
    hcheck("ch0_run_c1", int'(bus0.running[0]), 1);
    step(4'b0001, 4'b0000, 1'b0);
    step(4'b0001, 4'b0000, 1'b0);
    hcheck("ch0_run_c3", int'(bus0.running[0]), 1);
    step(4'b0001, 4'b0001, 1'b0);
    hcheck("ch0_count3", ch0(0), 3);
    hcheck("ch0_done_c4", int'(bus0.done[0]), 1);
    hcheck("ch0_idle_c4", int'(bus0.running[0]), 0);
    step(4'b0001, 4'b0000, 1'b0);
    hcheck("ch0_done_gone", int'(bus0.done[0]), 0);
    hcheck("ch0_hold3", ch0(0), 3);

    // Held start on ch1 for 10 cycles; stray stop on idle ch2
    for (int k = 0; k < 10; k++) begin
      step(4'b0011, (k == 5) ? 4'b0100 : 4'b0000, 1'b0);
    end
    hcheck("ch1_count9", ch0(1), 9);
    hcheck("ch2_untouched", ch0(2), 0);
    hcheck("ch2_no_done_run", int'({bus0.running[2], bus0.done[2]}), 0);

    // Restart priority on ch0
    step(4'b0010, 4'b0000, 1'b0);
    for (int k = 0; k < 6; k++) step(4'b0011, 4'b0000, 1'b0);
    step(4'b0010, 4'b0000, 1'b0);
    hcheck("ch0_count6", ch0(0), 6);
    step(4'b0011, 4'b0001, 1'b0);
    hcheck("restart_count0", ch0(0), 0);
    hcheck("restart_running", int'(bus0.running[0]), 1);
    hcheck("restart_no_done", int'(bus0.done[0]), 0);
    step(4'b0011, 4'b0011, 1'b0);
    hcheck("ch0_stop_count1", ch0(0), 1);

    // Overflow on ch3: wrap vs saturate
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b1000, 4'b0000, 1'b0);
    for (int k = 0; k < 32; k++) step(4'b1000, 4'b0000, 1'b0);
    hcheck("wrap_at_0", ch0(3), 0);
    hcheck("wrap_ovf", int'(bus0.overflow[3]), 1);
    step(4'b1000, 4'b0000, 1'b0);
    hcheck("wrap_final1", ch0(3), 1);
    hcheck("sat_hold31", ch1(3), 31);
    hcheck("sat_ovf", int'(bus1.overflow[3]), 1);
    step(4'b1000, 4'b1000, 1'b0);
    hcheck("sat_done", int'(bus1.done[3]), 1);
    hcheck("sat_stop31", ch1(3), 31);
    hcheck("wrap_stop2", ch0(3), 2);
    step(4'b0000, 4'b0000, 1'b0);
    hcheck("ovf_sticky_idle", int'(bus0.overflow[3]), 1);
    step(4'b1000, 4'b0000, 1'b0);
    hcheck("ovf_clear_start", int'({bus0.overflow[3], bus1.overflow[3]}), 0);
    step(4'b1000, 4'b1000, 1'b0);

    // Independent ch0/ch1 measurement
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0011, 4'b0000, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      step(4'b0011, (k == 4) ? 4'b0010 : ((k == 7) ? 4'b0001 : 4'b0000), 1'b0);
      if (k == 4) begin
        hcheck("ch1_count4", ch0(1), 4);
        hcheck("ch1_done_only", int'(bus0.done[1:0]), 2);
      end
    end
    hcheck("ch0_count7", ch0(0), 7);
    hcheck("ch0_done_only", int'(bus0.done[1:0]), 1);

    // Reset mid-run, start level held through reset
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0001, 4'b0000, 1'b0);
    step(4'b0001, 4'b0000, 1'b0);
    step(4'b0001, 4'b0000, 1'b0);
    step(4'b0001, 4'b0000, 1'b1);
    hcheck("midrst_count", int'(bus0.count_global), 0);
    hcheck("midrst_flags", int'({bus0.running, bus0.done, bus0.overflow}), 0);
    step(4'b0001, 4'b0000, 1'b0);
    hcheck("post_rst_start", int'(bus0.running[0]), 1);
    step(4'b0001, 4'b0001, 1'b0);
    hcheck("post_rst_count1", ch0(0), 1);

    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
